// File: rtl/gci_std_display_vram_arbiter_pkg.sv
// Shared display-VRAM arbiter definitions: default address width, FSM state
// encodings, owner encoding and the two-way fair-pick helper.
package gci_std_display_vram_arbiter_pkg;

  localparam int GCI_MEM_ADDR_N = 19;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARB_REQ = 3'd1,
    ST_GNT     = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_FINISH  = 3'd4
  } arb_state_e;

  typedef enum logic {
    OWN_WR = 1'b0,
    OWN_RD = 1'b1
  } owner_e;

  // When both sides are pending the side that did not own the bus last wins.
  function automatic logic rr_pick(input logic wr_pend, input logic rd_pend,
                                   input logic last_owner);
    logic pick;
    if (wr_pend && rd_pend) begin
      pick = ~last_owner;
    end else if (rd_pend) begin
      pick = 1'b1;
    end else begin
      pick = 1'b0;
    end
    return pick;
  endfunction

endpackage

// File: rtl/gci_std_display_vram_arbiter_rr.sv
// Two-way fair selector between the write requester and the display read
// requester; purely combinational, the parent latches the result.
module gci_std_display_vram_arbiter_rr
  import gci_std_display_vram_arbiter_pkg::*;
(
  input  logic iWR_PEND,
  input  logic iRD_PEND,
  input  logic iLAST_OWNER,
  output logic oANY,
  output logic oOWNER
);

  logic any_s;
  logic owner_s;

  // Pick the next owner from the pending set and the last owner.
  always_comb begin
    any_s   = iWR_PEND || iRD_PEND;
    owner_s = 1'b0;
    if (any_s) begin
      owner_s = rr_pick(iWR_PEND, iRD_PEND, iLAST_OWNER);
    end else begin
      owner_s = 1'b0;
    end
  end

  assign oANY   = any_s;
  assign oOWNER = owner_s;

endmodule

// File: rtl/gci_std_display_vram_arbiter.sv
// Arbitrates the VRAM command port between a write requester and the display
// read fetch, with bounded bursts, read draining and bus-ownership handshake.
module gci_std_display_vram_arbiter
  import gci_std_display_vram_arbiter_pkg::*;
#(
  parameter int P_MEM_ADDR_N = GCI_MEM_ADDR_N,
  parameter int P_BURST_MAX  = 16
) (
  input  logic                    iCLOCK,
  input  logic                    inRESET,
  input  logic                    iWR_REQ,
  output logic                    oWR_BUSY,
  input  logic [P_MEM_ADDR_N-1:0] iWR_ADDR,
  input  logic [31:0]             iWR_DATA,
  input  logic                    iRD_REQ,
  output logic                    oRD_BUSY,
  input  logic [P_MEM_ADDR_N-1:0] iRD_ADDR,
  output logic                    oRD_VALID,
  output logic [31:0]             oRD_DATA,
  output logic                    oVRAM_ARBIT_REQ,
  input  logic                    iVRAM_ARBIT_ACK,
  output logic                    oVRAM_ARBIT_FINISH,
  output logic                    oVRAM_ENA,
  input  logic                    iVRAM_BUSY,
  output logic                    oVRAM_RW,
  output logic [P_MEM_ADDR_N-1:0] oVRAM_ADDR,
  output logic [31:0]             oVRAM_DATA,
  input  logic                    iVRAM_VALID,
  input  logic [31:0]             iVRAM_DATA,
  output logic                    oVRAM_BUSY
);

  localparam int CNT_W = $clog2(P_BURST_MAX + 1);
  localparam logic [CNT_W-1:0] BURST_MAX_C = CNT_W'(P_BURST_MAX);
  localparam logic [CNT_W-1:0] CNT_ZERO_C  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE_C   = CNT_W'(1);

  arb_state_e       state_r;
  owner_e           owner_r;
  owner_e           last_owner_r;
  logic [CNT_W-1:0] beat_cnt_r;
  logic [CNT_W-1:0] outstd_r;
  logic             arbit_req_r;
  logic             finish_r;

  logic any_pend_s;
  logic pick_s;
  logic owner_req_s;
  logic burst_full_s;
  logic issue_s;
  logic owner_busy_s;
  logic rd_inc_s;
  logic rd_dec_s;
  logic drain_done_s;

  gci_std_display_vram_arbiter_rr u_rr (
    .iWR_PEND    (iWR_REQ),
    .iRD_PEND    (iRD_REQ),
    .iLAST_OWNER (last_owner_r),
    .oANY        (any_pend_s),
    .oOWNER      (pick_s)
  );

  // Per-cycle grant qualifiers derived from the latched owner.
  always_comb begin
    owner_req_s  = (owner_r == OWN_RD) ? iRD_REQ : iWR_REQ;
    burst_full_s = (beat_cnt_r == BURST_MAX_C);
    issue_s      = (state_r == ST_GNT) && owner_req_s && !iVRAM_BUSY && !burst_full_s;
    owner_busy_s = iVRAM_BUSY || burst_full_s || (state_r != ST_GNT);
    rd_inc_s     = issue_s && (owner_r == OWN_RD) && (outstd_r != BURST_MAX_C);
    rd_dec_s     = iVRAM_VALID && (outstd_r != CNT_ZERO_C);
    // A return arriving this cycle that empties the counter also ends the drain.
    drain_done_s = (outstd_r == CNT_ZERO_C) || ((outstd_r == CNT_ONE_C) && iVRAM_VALID);
  end

  // Grant FSM with registered ownership request and release pulse.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state_r      <= ST_IDLE;
      owner_r      <= OWN_WR;
      last_owner_r <= OWN_WR;
      beat_cnt_r   <= CNT_ZERO_C;
      arbit_req_r  <= 1'b0;
      finish_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (any_pend_s) begin
            owner_r     <= owner_e'(pick_s);
            arbit_req_r <= 1'b1;
            state_r     <= ST_ARB_REQ;
          end
        end
        ST_ARB_REQ: begin
          if (iVRAM_ARBIT_ACK) begin
            arbit_req_r <= 1'b0;
            beat_cnt_r  <= CNT_ZERO_C;
            state_r     <= ST_GNT;
          end
        end
        ST_GNT: begin
          if (issue_s) begin
            beat_cnt_r <= beat_cnt_r + CNT_ONE_C;
          end
          if (!owner_req_s || burst_full_s) begin
            if (owner_r == OWN_RD) begin
              state_r <= ST_DRAIN;
            end else begin
              finish_r <= 1'b1;
              state_r  <= ST_FINISH;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_done_s) begin
            finish_r <= 1'b1;
            state_r  <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          finish_r     <= 1'b0;
          last_owner_r <= owner_r;
          state_r      <= ST_IDLE;
        end
        default: begin
          arbit_req_r <= 1'b0;
          finish_r    <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  // Reads issued but not yet returned; simultaneous issue and return cancel.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      outstd_r <= CNT_ZERO_C;
    end else begin
      case ({rd_inc_s, rd_dec_s})
        2'b10:   outstd_r <= outstd_r + CNT_ONE_C;
        2'b01:   outstd_r <= outstd_r - CNT_ONE_C;
        default: outstd_r <= outstd_r;
      endcase
    end
  end

  // Command port is steered straight from the owner so beats cost no latency.
  always_comb begin
    oVRAM_ENA  = 1'b0;
    oVRAM_RW   = 1'b0;
    oVRAM_ADDR = {P_MEM_ADDR_N{1'b0}};
    oVRAM_DATA = 32'h0000_0000;
    if (state_r == ST_GNT) begin
      oVRAM_ENA = issue_s;
      if (owner_r == OWN_RD) begin
        oVRAM_RW   = 1'b0;
        oVRAM_ADDR = iRD_ADDR;
        oVRAM_DATA = 32'h0000_0000;
      end else begin
        oVRAM_RW   = 1'b1;
        oVRAM_ADDR = iWR_ADDR;
        oVRAM_DATA = iWR_DATA;
      end
    end else begin
      oVRAM_ENA = 1'b0;
    end
  end

  // Requester back-pressure: the non-owner is always held off.
  always_comb begin
    oWR_BUSY = 1'b1;
    oRD_BUSY = 1'b1;
    if (owner_r == OWN_RD) begin
      oRD_BUSY = owner_busy_s;
    end else begin
      oWR_BUSY = owner_busy_s;
    end
  end

  assign oVRAM_ARBIT_REQ    = arbit_req_r;
  assign oVRAM_ARBIT_FINISH = finish_r;
  assign oRD_VALID          = iVRAM_VALID && (outstd_r != CNT_ZERO_C);
  assign oRD_DATA           = iVRAM_DATA;
  assign oVRAM_BUSY         = 1'b0;

endmodule

// File: tb/tb_gci_std_display_vram_arbiter.sv
// Scoreboard bench for the display VRAM arbiter with a small VRAM/ack model.
module tb_gci_std_display_vram_arbiter;

  localparam int AW = 19;
  localparam int BM = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_req = 1'b0, rd_req = 1'b0;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic [31:0]   wr_data = 32'h0;
  logic          ack = 1'b0, vram_busy = 1'b0, vram_valid = 1'b0;
  logic [31:0]   vram_data = 32'h0;
  logic          wr_busy, rd_busy, rd_valid, arb_req, fin, v_ena, v_rw, v_obusy;
  logic [31:0]   rd_data, v_data;
  logic [AW-1:0] v_addr;

  always #5 clk = ~clk;

  gci_std_display_vram_arbiter #(.P_MEM_ADDR_N(AW), .P_BURST_MAX(BM)) dut (
    .iCLOCK(clk), .inRESET(rst_n),
    .iWR_REQ(wr_req), .oWR_BUSY(wr_busy), .iWR_ADDR(wr_addr), .iWR_DATA(wr_data),
    .iRD_REQ(rd_req), .oRD_BUSY(rd_busy), .iRD_ADDR(rd_addr),
    .oRD_VALID(rd_valid), .oRD_DATA(rd_data),
    .oVRAM_ARBIT_REQ(arb_req), .iVRAM_ARBIT_ACK(ack), .oVRAM_ARBIT_FINISH(fin),
    .oVRAM_ENA(v_ena), .iVRAM_BUSY(vram_busy), .oVRAM_RW(v_rw),
    .oVRAM_ADDR(v_addr), .oVRAM_DATA(v_data),
    .iVRAM_VALID(vram_valid), .iVRAM_DATA(vram_data), .oVRAM_BUSY(v_obusy)
  );

  typedef struct packed { logic rw; logic [AW-1:0] addr; logic [31:0] data; } cmd_t;
  typedef struct packed { int due; logic [31:0] data; } ret_t;

  cmd_t          cmd_q[$];
  logic [31:0]   exp_rd[$];
  ret_t          ret_q[$];
  int            grant_q[$];

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, wr_left = 0, rd_left = 0, rd_lat = 3, ack_dly = 2, req_cnt = 0;
  int gnt_beats = 0, finish_cnt = 0, finish_cyc = 0, drop_cyc = 0, ena_cnt = 0, ret_cnt = 0;
  logic gnt_rw = 1'b0;
  bit   wr_acc, rd_acc, spur = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd_f(input logic [AW-1:0] a);
    return {13'h0, a} ^ 32'hC0DE_0000;
  endfunction

  // One clock: sample/score at negedge, then advance requesters and VRAM model.
  task automatic step();
    cmd_t c;
    ret_t r;
    wr_acc = 1'b0;
    rd_acc = 1'b0;
    @(negedge clk);
    if (rst_n) begin
      if (wr_req && !wr_busy) begin
        cmd_q.push_back({1'b1, wr_addr, wr_data});
        wr_acc = 1'b1;
      end
      if (rd_req && !rd_busy) begin
        cmd_q.push_back({1'b0, rd_addr, 32'h0});
        exp_rd.push_back(rd_f(rd_addr));
        rd_acc = 1'b1;
      end
      if (v_ena) begin
        ena_cnt++;
        if (cmd_q.size() == 0) check_val("ena_unexpected", 64'd1, 64'd0);
        else begin
          c = cmd_q.pop_front();
          check_val("cmd", 64'({v_rw, v_addr, v_data}), 64'(c));
        end
        if (gnt_beats == 0) gnt_rw = v_rw;
        gnt_beats++;
        if (!v_rw) begin
          r.due = cyc + rd_lat;
          r.data = rd_f(v_addr);
          ret_q.push_back(r);
        end
      end
      if (vram_valid) begin
        if (exp_rd.size() == 0) check_val("stray_valid", 64'(rd_valid), 64'd0);
        else begin
          ret_cnt++;
          check_val("rd_data", {31'h0, rd_valid, rd_data}, {31'h0, 1'b1, exp_rd.pop_front()});
        end
      end
      if (vram_busy) check_val("stall", 64'({v_ena, wr_busy, rd_busy}), 64'(3'b011));
      if (arb_req || fin) check_val("busy_gap", 64'({wr_busy, rd_busy, v_ena}), 64'(3'b110));
      if (fin) begin
        finish_cnt++;
        finish_cyc = cyc;
        check_val("drained", 64'(exp_rd.size()), 64'd0);
        grant_q.push_back(int'(gnt_rw) * 256 + gnt_beats);
        gnt_beats = 0;
      end
      req_cnt = arb_req ? req_cnt + 1 : 0;
    end else begin
      req_cnt = 0;
    end
    @(posedge clk);
    cyc++;
    #1;
    if (wr_acc) begin
      wr_left--; wr_addr++; wr_data += 32'h0101_0101;
      if (wr_left == 0) begin wr_req = 1'b0; drop_cyc = cyc; end
    end
    if (rd_acc) begin
      rd_left--; rd_addr++;
      if (rd_left == 0) rd_req = 1'b0;
    end
    ack = (req_cnt >= ack_dly);
    if (ret_q.size() != 0 && ret_q[0].due <= cyc) begin
      r = ret_q.pop_front();
      vram_valid = 1'b1; vram_data = r.data;
    end else if (spur) begin
      spur = 1'b0; vram_valid = 1'b1; vram_data = 32'hDEAD_BEEF;
    end else begin
      vram_valid = 1'b0; vram_data = 32'h0;
    end
  endtask

  task automatic check_rst();
    check_val("rst_ctrl", 64'({arb_req, fin, v_ena, rd_valid, wr_busy, rd_busy, v_rw}), 64'(7'b0000110));
    check_val("rst_addr", 64'(v_addr), 64'd0);
    check_val("rst_data", 64'(v_data), 64'd0);
  endtask

  task automatic apply_reset(input bit keep_ret);
    rst_n = 1'b0;
    wr_req = 1'b0; rd_req = 1'b0; wr_left = 0; rd_left = 0;
    ack = 1'b0; vram_busy = 1'b0; vram_valid = 1'b0; spur = 1'b0;
    req_cnt = 0; gnt_beats = 0;
    cmd_q.delete(); exp_rd.delete(); grant_q.delete();
    if (!keep_ret) ret_q.delete();
    #1;
    check_rst();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic start_wr(input int n, input logic [AW-1:0] a, input logic [31:0] d);
    wr_left = n; wr_addr = a; wr_data = d; wr_req = 1'b1;
  endtask

  task automatic start_rd(input int n, input logic [AW-1:0] a);
    rd_left = n; rd_addr = a; rd_req = 1'b1;
  endtask

  task automatic wait_fin(input int n, input int budget);
    int target = finish_cnt + n;
    int b = 0;
    while (finish_cnt < target && b < budget) begin step(); b++; end
    check_val("finish_count", 64'(finish_cnt), 64'(target));
    repeat (3) step();
  endtask

  task automatic wait_beats(input int n, input int budget);
    int b = 0;
    while (gnt_beats < n && b < budget) begin step(); b++; end
    check_val("beats_reached", 64'(gnt_beats >= n), 64'd1);
  endtask

  task automatic next_grant(input string tag, input int exp);
    int g = -1;
    if (grant_q.size() != 0) g = grant_q.pop_front();
    check_val(tag, 64'(g), 64'(exp));
  endtask

  initial begin
    int base, fin_before;
    apply_reset(1'b0);

    // Single write beat.
    base = ena_cnt;
    start_wr(1, 19'h00010, 32'hA5A5_A5A5);
    wait_fin(1, 60);
    check_val("t1_beats", 64'(ena_cnt - base), 64'd1);
    check_val("t1_fin_lat", 64'(finish_cyc - drop_cyc), 64'd1);
    next_grant("t1_grant", 256 + 1);

    // Both pending out of reset: read wins first, then write.
    apply_reset(1'b0);
    rd_lat = 3;
    start_wr(4, 19'h00100, 32'h1111_0000);
    start_rd(4, 19'h00200);
    wait_fin(2, 200);
    next_grant("t2_grant0", 4);
    next_grant("t2_grant1", 256 + 4);
    check_val("t2_cmd_left", 64'(cmd_q.size()), 64'd0);

    // Long write splits into bounded bursts.
    start_wr(40, 19'h01000, 32'h0);
    wait_fin(3, 400);
    next_grant("t3_grant0", 256 + 16);
    next_grant("t3_grant1", 256 + 16);
    next_grant("t3_grant2", 256 + 8);

    // Command stall mid read burst.
    start_rd(8, 19'h00300);
    wait_beats(3, 60);
    vram_busy = 1'b1;
    repeat (3) step();
    vram_busy = 1'b0;
    wait_fin(1, 200);
    next_grant("t4_grant", 8);

    // Slow returns, one coincident with an issue, then a spurious return.
    rd_lat = 6;
    base = ret_cnt;
    start_rd(5, 19'h00400);
    wait_beats(3, 60);
    vram_busy = 1'b1;
    repeat (3) step();
    vram_busy = 1'b0;
    wait_fin(1, 200);
    next_grant("t5_grant", 5);
    check_val("t5_returns", 64'(ret_cnt - base), 64'd5);
    spur = 1'b1;
    repeat (3) step();

    // Reset during a read grant with two reads in flight.
    start_rd(8, 19'h00500);
    wait_beats(2, 60);
    check_val("t6_inflight", 64'(ret_q.size()), 64'd2);
    fin_before = finish_cnt;
    apply_reset(1'b1);
    repeat (12) step();
    check_val("t6_no_finish", 64'(finish_cnt), 64'(fin_before));
    check_val("t6_returns_sent", 64'(ret_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
